// File: rtl/psum_accum_bank.sv
// psum_accum_bank: multi-bank per-column partial-sum accumulator with a
// saturating, optionally ReLU'd single-word drain over a valid/ready port.
// Optional feature macro: CORELET_ACC_SHIFT_EN (round-half-up arithmetic
// right shift by OUT_SHIFT applied to each accumulator at drain time).
module psum_accum_bank #(
  parameter int COL       = 8,
  parameter int PSUM_BW   = 16,
  parameter int ACC_BW    = 20,
  parameter int NBANK     = 4,
  parameter int OUT_SHIFT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [COL*PSUM_BW-1:0]     in_psum,
  input  logic [COL-1:0]             in_valid,
  input  logic [$clog2(NBANK)-1:0]   acc_bank,
  output logic                       acc_ready,
  input  logic                       clr_en,
  input  logic [$clog2(NBANK)-1:0]   clr_bank,
  input  logic                       relu_en,
  input  logic                       drain_req,
  input  logic [$clog2(NBANK)-1:0]   drain_bank,
  input  logic                       drain_clr,
  output logic [COL*PSUM_BW-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic [COL-1:0]             sat_flag
);

  localparam int BANK_W = $clog2(NBANK);

`ifdef CORELET_ACC_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  localparam logic [ACC_BW-1:0]  ACC_MAX  = {1'b0, {(ACC_BW-1){1'b1}}};
  localparam logic [ACC_BW-1:0]  ACC_MIN  = {1'b1, {(ACC_BW-1){1'b0}}};
  localparam logic [PSUM_BW-1:0] PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic [PSUM_BW-1:0] PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};
  localparam int                 RND_SH   = (OUT_SHIFT > 32'sd0) ? (OUT_SHIFT - 32'sd1) : 32'sd0;
  localparam logic [ACC_BW-1:0]  RND_ADD  = {{(ACC_BW-1){1'b0}}, 1'b1} << RND_SH;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Sign-extend one psum lane to accumulator width.
  function automatic logic [ACC_BW-1:0] sext_psum(input logic [PSUM_BW-1:0] p);
    logic signed [PSUM_BW-1:0] ps;
    ps = p;
    return ACC_BW'(ps);
  endfunction

  // One extra bit of headroom so overflow is visible in the top two bits.
  function automatic logic [ACC_BW:0] add_wide(input logic [ACC_BW-1:0] a,
                                               input logic [ACC_BW-1:0] b);
    return {a[ACC_BW-1], a} + {b[ACC_BW-1], b};
  endfunction

  function automatic logic acc_ovf(input logic [ACC_BW:0] s);
    return s[ACC_BW] ^ s[ACC_BW-1];
  endfunction

  function automatic logic [ACC_BW-1:0] sat_acc(input logic [ACC_BW:0] s);
    if (acc_ovf(s)) begin
      return s[ACC_BW] ? ACC_MIN : ACC_MAX;
    end else begin
      return s[ACC_BW-1:0];
    end
  endfunction

  // True when the accumulator value does not fit the psum width.
  function automatic logic narrow_clip(input logic [ACC_BW-1:0] a);
    logic [ACC_BW-PSUM_BW:0] upper;
    upper = a[ACC_BW-1:PSUM_BW-1];
    return !((&upper) || (~|upper));
  endfunction

  function automatic logic [PSUM_BW-1:0] narrow_sat(input logic [ACC_BW-1:0] a);
    if (narrow_clip(a)) begin
      return a[ACC_BW-1] ? PSUM_MIN : PSUM_MAX;
    end else begin
      return a[PSUM_BW-1:0];
    end
  endfunction

  // Drain-time scaling: rounding add saturates before the arithmetic shift.
  function automatic logic [ACC_BW-1:0] drain_scale(input logic [ACC_BW-1:0] a);
    logic signed [ACC_BW-1:0] s;
    if (SHIFT_EN && (OUT_SHIFT > 32'sd0)) begin
      s = sat_acc(add_wide(a, RND_ADD));
      return s >>> OUT_SHIFT;
    end else begin
      return a;
    end
  endfunction

  state_t                                state_q, state_d;
  logic [NBANK-1:0][COL-1:0][ACC_BW-1:0] acc_q, acc_d;
  logic [BANK_W-1:0]                     dbank_q, dbank_d;
  logic                                  dclr_q, dclr_d;
  logic [COL*PSUM_BW-1:0]                out_data_q, out_data_d;
  logic                                  out_valid_q, out_valid_d;
  logic [COL-1:0]                        sat_flag_q, sat_flag_d;

  logic                                  handshake_s;
  logic [COL-1:0][ACC_BW:0]              sum_s;
  logic [COL-1:0][ACC_BW-1:0]            scaled_s;
  logic [COL-1:0][PSUM_BW-1:0]           nar_s;

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign sat_flag    = sat_flag_q;
  assign handshake_s = (state_q == ST_DRAIN) && out_valid_q && out_ready;

  // State register plus all datapath flops, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      dbank_q     <= '0;
      dclr_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      dbank_q     <= dbank_d;
      dclr_q      <= dclr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  // Next-state: start a drain from IDLE, return once the word is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (drain_req) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs: busy and bank-availability for accumulation.
  always_comb begin
    busy      = 1'b0;
    acc_ready = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (drain_req && (acc_bank == drain_bank)) begin
          acc_ready = 1'b0;
        end else begin
          acc_ready = 1'b1;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (acc_bank == dbank_q) begin
          acc_ready = 1'b0;
        end else begin
          acc_ready = 1'b1;
        end
      end
      default: begin
        busy      = 1'b0;
        acc_ready = 1'b0;
      end
    endcase
  end

  // Bank clears, accumulation (after clears), drain capture and sticky flags.
  always_comb begin
    acc_d       = acc_q;
    dbank_d     = dbank_q;
    dclr_d      = dclr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sat_flag_d  = sat_flag_q;
    sum_s       = '0;
    scaled_s    = '0;
    nar_s       = '0;

    if (clr_en) begin
      acc_d[clr_bank] = '0;
    end else begin
      acc_d[clr_bank] = acc_q[clr_bank];
    end

    if (handshake_s && dclr_q) begin
      acc_d[dbank_q] = '0;
    end else begin
      acc_d[dbank_q] = acc_d[dbank_q];
    end

    for (int c = 0; c < COL; c++) begin
      sum_s[c] = add_wide(acc_d[acc_bank][c], sext_psum(in_psum[c*PSUM_BW +: PSUM_BW]));
      if (acc_ready && in_valid[c]) begin
        acc_d[acc_bank][c] = sat_acc(sum_s[c]);
        sat_flag_d[c]      = sat_flag_d[c] | acc_ovf(sum_s[c]);
      end else begin
        acc_d[acc_bank][c] = acc_d[acc_bank][c];
      end
    end

    // The drained word is built from bank contents before this edge.
    if ((state_q == ST_IDLE) && drain_req) begin
      for (int c = 0; c < COL; c++) begin
        scaled_s[c] = drain_scale(acc_q[drain_bank][c]);
        nar_s[c]    = narrow_sat(scaled_s[c]);
        if (relu_en && nar_s[c][PSUM_BW-1]) begin
          nar_s[c] = '0;
        end else begin
          nar_s[c] = nar_s[c];
        end
        sat_flag_d[c]                        = sat_flag_d[c] | narrow_clip(scaled_s[c]);
        out_data_d[c*PSUM_BW +: PSUM_BW]     = nar_s[c];
      end
      out_valid_d = 1'b1;
      dbank_d     = drain_bank;
      dclr_d      = drain_clr;
    end else if (handshake_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

endmodule
